regfile_sb: RTL and testbench

Parametrised successor to the pipeline register file: NREGS general registers of WIDTH bits, two combinational read ports, two writeback ports (E and M), an optional write-through bypass, and a per-register pending-write scoreboard. Decode uses it to read operands, register in-flight destinations at issue, and detect operand readiness. It sits between the decode and writeback stages and drives the stall/ready information used by the hazard unit.

---
 rtl/regfile_sb_pkg.sv | 28 ++
 rtl/regfile_sb_counter.sv | 27 ++
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 139 +++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// the "no register" index and named register indices.
package regfile_sb_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_AW    = 4;
  localparam int DEF_NREGS = 15;
  localparam int DEF_CNTW  = 2;

  localparam logic [DEF_AW-1:0] RNONE = '1;

  localparam logic [DEF_AW-1:0] RAX = 4'd0;
  localparam logic [DEF_AW-1:0] RCX = 4'd1;
  localparam logic [DEF_AW-1:0] RDX = 4'd2;
  localparam logic [DEF_AW-1:0] RBX = 4'd3;
  localparam logic [DEF_AW-1:0] RSP = 4'd4;
  localparam logic [DEF_AW-1:0] RBP = 4'd5;
  localparam logic [DEF_AW-1:0] RSI = 4'd6;
  localparam logic [DEF_AW-1:0] RDI = 4'd7;
  localparam logic [DEF_AW-1:0] R8  = 4'd8;
  localparam logic [DEF_AW-1:0] R9  = 4'd9;
  localparam logic [DEF_AW-1:0] R10 = 4'd10;
  localparam logic [DEF_AW-1:0] R11 = 4'd11;
  localparam logic [DEF_AW-1:0] R12 = 4'd12;
  localparam logic [DEF_AW-1:0] R13 = 4'd13;
  localparam logic [DEF_AW-1:0] R14 = 4'd14;

endpackage

// File: rtl/regfile_sb_counter.sv
// Outstanding-write counter for one register: up on issue, down on writeback,
// holds at zero and flags an underflow when a writeback finds nothing pending.
module sb_counter #(
  parameter int CNTW = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            underflow
);

  // Saturation is prevented upstream by refusing the issue, so inc never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNTW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNTW'(1);
    end
  end

  assign underflow = dec && !inc && (cnt == '0);

endmodule

// File: rtl/regfile_sb.sv
// Register file with two read ports, E/M writeback ports, optional write-through
// bypass and a per-register pending-write scoreboard for the hazard unit.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AW     = DEF_AW,
  parameter int NREGS  = DEF_NREGS,
  parameter int CNTW   = DEF_CNTW,
  parameter int BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             readyA,
  output logic             readyB,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_dstE,
  input  logic [AW-1:0]    issue_dstM,
  output logic             issue_ok,
  input  logic [AW-1:0]    dstE,
  input  logic [AW-1:0]    dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic [AW-1:0]    dbg_idx,
  output logic [WIDTH-1:0] dbg_val,
  output logic             sb_err
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [CNTW-1:0]  pend [NREGS];
  logic [NREGS-1:0] dec;
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] named;
  logic [NREGS-1:0] full;
  logic [NREGS-1:0] uflow;

  // A full destination blocks the whole issue, even if it drains this cycle.
  assign issue_ok = !(issue_valid && |(named & full));

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);

      assign dec[gi]   = (dstE == IDX) || (dstM == IDX);
      assign named[gi] = (issue_dstE == IDX) || (issue_dstM == IDX);
      assign full[gi]  = (pend[gi] == '1);
      assign inc[gi]   = issue_valid && issue_ok && named[gi];

      sb_counter #(.CNTW(CNTW)) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (inc[gi]),
        .dec       (dec[gi]),
        .cnt       (pend[gi]),
        .underflow (uflow[gi])
      );

      // M port has priority when both ports target this register.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          regs[gi] <= '0;
        end else if (dstM == IDX) begin
          regs[gi] <= valM;
        end else if (dstE == IDX) begin
          regs[gi] <= valE;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_err <= 1'b0;
    end else if (|uflow) begin
      sb_err <= 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] src, input logic byp);
    logic hit;
    hit      = 1'b0;
    read_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src == AW'(i)) begin
        hit      = 1'b1;
        read_val = regs[i];
      end
    end
    if (byp && hit) begin
      if (dstM == src) begin
        read_val = valM;
      end else if (dstE == src) begin
        read_val = valE;
      end
    end
  endfunction

  // Unimplemented/RNONE sources are always ready.
  function automatic logic read_ready(input logic [AW-1:0] src);
    read_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if (src == AW'(i)) begin
        read_ready = (pend[i] == '0) ||
                     ((BYPASS != 0) && (pend[i] == CNTW'(1)) && dec[i]);
      end
    end
  endfunction

  always_comb begin
    valA    = read_val(srcA, BYPASS != 0);
    valB    = read_val(srcB, BYPASS != 0);
    dbg_val = read_val(dbg_idx, 1'b0);
    readyA  = read_ready(srcA);
    readyB  = read_ready(srcB);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb, with a second instance built
// without bypass to compare same-cycle read behaviour.
module tb_regfile_sb;

  localparam logic [3:0] RN = 4'hF;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  srcA, srcB, issue_dstE, issue_dstM, dstE, dstM, dbg_idx;
  logic        issue_valid;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB, dbg_val;
  logic        readyA, readyB, issue_ok, sb_err;
  logic [63:0] nb_valA, nb_valB, nb_dbg_val;
  logic        nb_readyA, nb_readyB, nb_issue_ok, nb_sb_err;

  always #5 clock = ~clock;

  regfile_sb #(.BYPASS(1)) u_dut (
    .clock(clock), .reset(reset), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .readyA(readyA), .readyB(readyB),
    .issue_valid(issue_valid), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
    .issue_ok(issue_ok), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .dbg_idx(dbg_idx), .dbg_val(dbg_val), .sb_err(sb_err)
  );

  regfile_sb #(.BYPASS(0)) u_dut_nb (
    .clock(clock), .reset(reset), .srcA(srcA), .srcB(srcB),
    .valA(nb_valA), .valB(nb_valB), .readyA(nb_readyA), .readyB(nb_readyB),
    .issue_valid(issue_valid), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
    .issue_ok(nb_issue_ok), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .dbg_idx(dbg_idx), .dbg_val(nb_dbg_val), .sb_err(nb_sb_err)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  idE, idM, dE, dM;
    logic [63:0] vE, vM;
    logic [3:0]  sA, sB, dbg;
    logic [63:0] eA, eB;
    logic        erA, erB, eok, eerr;
    logic [63:0] eA_nb, edbg;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_dstE = v.idE; issue_dstM = v.idM;
    dstE = v.dE; dstM = v.dM; valE = v.vE; valM = v.vM;
    srcA = v.sA; srcB = v.sB; dbg_idx = v.dbg;
  endtask

  initial begin
    //          iv idE idM dE  dM  vE       vM       sA  sB  dbg eA       eB       rA rB ok er eA_nb    edbg
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       3,  RN, 3,  0,       0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{1, 3,  RN, RN, RN, 0,       0,       3,  RN, 3,  0,       0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       3,  RN, 3,  0,       0,       0, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, 3,  RN, 'h1234,  0,       3,  RN, 3,  'h1234,  0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       3,  RN, 3,  'h1234,  0,       1, 1, 1, 0, 'h1234,  'h1234});
    vecs.push_back('{1, 5,  5,  RN, RN, 0,       0,       5,  RN, 5,  0,       0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, 5,  5,  'hAA,    'hBB,    5,  5,  5,  'hBB,    'hBB,    1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       5,  3,  5,  'hBB,    'h1234,  1, 1, 1, 0, 'hBB,    'hBB});
    vecs.push_back('{1, 2,  RN, RN, RN, 0,       0,       2,  RN, RN, 0,       0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{1, 2,  RN, RN, RN, 0,       0,       2,  RN, RN, 0,       0,       0, 1, 1, 0, 0,       0});
    vecs.push_back('{1, 2,  RN, RN, RN, 0,       0,       2,  RN, RN, 0,       0,       0, 1, 1, 0, 0,       0});
    vecs.push_back('{1, 2,  RN, RN, RN, 0,       0,       2,  RN, RN, 0,       0,       0, 1, 0, 0, 0,       0});
    vecs.push_back('{1, RN, 6,  RN, RN, 0,       0,       2,  6,  RN, 0,       0,       0, 1, 1, 0, 0,       0});
    vecs.push_back('{1, 2,  RN, 2,  RN, 'h22,    0,       2,  6,  2,  'h22,    0,       0, 0, 0, 0, 0,       0});
    vecs.push_back('{1, 2,  RN, 2,  RN, 'h33,    0,       2,  RN, 2,  'h33,    0,       0, 1, 1, 0, 'h22,    'h22});
    vecs.push_back('{0, RN, RN, 2,  RN, 'h44,    0,       2,  RN, 2,  'h44,    0,       0, 1, 1, 0, 'h33,    'h33});
    vecs.push_back('{0, RN, RN, RN, 2,  0,       'h55,    2,  RN, 2,  'h55,    0,       1, 1, 1, 0, 'h44,    'h44});
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       2,  RN, 2,  'h55,    0,       1, 1, 1, 0, 'h55,    'h55});
    vecs.push_back('{1, RN, RN, RN, RN, 0,       0,       RN, 14, RN, 0,       0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, RN, 7,  0,       'h77,    7,  RN, 7,  'h77,    0,       1, 1, 1, 0, 0,       0});
    vecs.push_back('{0, RN, RN, RN, RN, 0,       0,       7,  6,  7,  'h77,    0,       1, 0, 1, 1, 'h77,    'h77});
    vecs.push_back('{1, 4,  RN, RN, RN, 0,       0,       4,  RN, 3,  0,       0,       1, 1, 1, 1, 0,       'h1234});

    drive(vecs[0]);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i]);
      #2;
      $display("vec %0d srcA=%h valA=%h readyA=%b readyB=%b issue_ok=%b sb_err=%b dbg=%h",
               i, srcA, valA, readyA, readyB, issue_ok, sb_err, dbg_val);
      chk($sformatf("v%0d valA", i), valA, vecs[i].eA);
      chk($sformatf("v%0d valB", i), valB, vecs[i].eB);
      chk($sformatf("v%0d readyA", i), 64'(readyA), 64'(vecs[i].erA));
      chk($sformatf("v%0d readyB", i), 64'(readyB), 64'(vecs[i].erB));
      chk($sformatf("v%0d issue_ok", i), 64'(issue_ok), 64'(vecs[i].eok));
      chk($sformatf("v%0d sb_err", i), 64'(sb_err), 64'(vecs[i].eerr));
      chk($sformatf("v%0d nb_valA", i), nb_valA, vecs[i].eA_nb);
      chk($sformatf("v%0d dbg_val", i), dbg_val, vecs[i].edbg);
    end

    // Asynchronous reset mid-cycle with pend[4] and pend[6] outstanding.
    @(negedge clock);
    issue_valid = 1'b0; issue_dstE = RN; issue_dstM = RN;
    dstE = RN; dstM = RN; srcA = 4; srcB = 6; dbg_idx = 3;
    #2;
    $display("pre-reset readyA=%b readyB=%b dbg=%h sb_err=%b", readyA, readyB, dbg_val, sb_err);
    chk("pre_rst readyA", 64'(readyA), 64'd0);
    chk("pre_rst readyB", 64'(readyB), 64'd0);
    chk("pre_rst dbg_val", dbg_val, 64'h1234);
    #1 reset = 1'b0;
    #1;
    $display("in-reset readyA=%b readyB=%b dbg=%h sb_err=%b issue_ok=%b", readyA, readyB, dbg_val, sb_err, issue_ok);
    chk("rst readyA", 64'(readyA), 64'd1);
    chk("rst readyB", 64'(readyB), 64'd1);
    chk("rst dbg_val", dbg_val, 64'd0);
    chk("rst sb_err", 64'(sb_err), 64'd0);
    chk("rst issue_ok", 64'(issue_ok), 64'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    srcA = 3;
    #1;
    $display("post-reset valA=%h readyA=%b sb_err=%b", valA, readyA, sb_err);
    chk("post_rst valA", valA, 64'd0);
    chk("post_rst readyA", 64'(readyA), 64'd1);
    chk("post_rst sb_err", 64'(sb_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
